// File: rtl/pingpong_frame_buf.sv
// pingpong_frame_buf: multi-bank ping-pong frame buffer; define PINGPONG_FRAME_BUF_LEN_EN for rd_len/rd_first outputs
module pingpong_frame_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BANKS  = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_valid,
    output logic                                 wr_ready,
    input  logic [DATA_WIDTH-1:0]                wr_data,
    input  logic                                 wr_last,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [DATA_WIDTH-1:0]                rd_data,
    output logic                                 rd_last,
`ifdef PINGPONG_FRAME_BUF_LEN_EN
    output logic [ADDR_WIDTH:0]                  rd_len,
    output logic                                 rd_first,
`endif
    output logic [$clog2(NUM_BANKS+1)-1:0]       frames_avail
);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS+1);
    localparam int LW = ADDR_WIDTH + 1;
    localparam int DEPTH = 2**ADDR_WIDTH;

    generate
        if (NUM_BANKS < 2 || NUM_BANKS > 8) begin : g_bad_banks
            $error("pingpong_frame_buf: NUM_BANKS must be in 2..8");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] r_mem [NUM_BANKS][DEPTH];
    logic [LW-1:0]         r_len [NUM_BANKS];
    logic [BW-1:0]         r_wr_bank, r_rd_bank;
    logic [ADDR_WIDTH-1:0] r_wr_idx, r_rd_idx;
    logic [CW-1:0]         r_frames;
    logic                  r_rd_valid, r_rd_last;
    logic [DATA_WIDTH-1:0] r_rd_data;
`ifdef PINGPONG_FRAME_BUF_LEN_EN
    logic [LW-1:0]         r_rd_len;
    logic                  r_rd_first;
`endif

    logic          w_wr_fire, w_close, w_issue, w_last_word, w_last_issue;
    logic [BW-1:0] w_wr_bank_nxt, w_rd_bank_nxt;

    always_comb begin
        w_wr_fire     = wr_valid && wr_ready;
        w_close       = w_wr_fire && (wr_last || (&r_wr_idx));
        w_issue       = (r_frames != '0) && (!r_rd_valid || rd_ready);
        w_last_word   = ({1'b0, r_rd_idx} == r_len[r_rd_bank] - LW'(1));
        w_last_issue  = w_issue && w_last_word;
        // explicit compare-and-clear so non-power-of-two bank counts wrap correctly
        w_wr_bank_nxt = (r_wr_bank == BW'(NUM_BANKS-1)) ? '0 : r_wr_bank + BW'(1);
        w_rd_bank_nxt = (r_rd_bank == BW'(NUM_BANKS-1)) ? '0 : r_rd_bank + BW'(1);
    end

    assign wr_ready     = (r_frames < CW'(NUM_BANKS));
    assign frames_avail = r_frames;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign rd_last      = r_rd_last;
`ifdef PINGPONG_FRAME_BUF_LEN_EN
    assign rd_len       = r_rd_len;
    assign rd_first     = r_rd_first;
`endif

    // storage is never reset; only closed banks are ever read back
    always_ff @(posedge clk) begin
        if (w_wr_fire)
            r_mem[r_wr_bank][r_wr_idx] <= wr_data;
        if (w_close)
            r_len[r_wr_bank] <= {1'b0, r_wr_idx} + LW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank  <= '0;
            r_rd_bank  <= '0;
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_frames   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_rd_data  <= '0;
`ifdef PINGPONG_FRAME_BUF_LEN_EN
            r_rd_len   <= '0;
            r_rd_first <= 1'b0;
`endif
        end else begin
            if (w_wr_fire) begin
                r_wr_idx  <= w_close ? '0 : r_wr_idx + ADDR_WIDTH'(1);
                r_wr_bank <= w_close ? w_wr_bank_nxt : r_wr_bank;
            end
            if (w_issue) begin
                r_rd_data  <= r_mem[r_rd_bank][r_rd_idx];
                r_rd_valid <= 1'b1;
                r_rd_last  <= w_last_word;
`ifdef PINGPONG_FRAME_BUF_LEN_EN
                r_rd_len   <= r_len[r_rd_bank];
                r_rd_first <= (r_rd_idx == '0);
`endif
                r_rd_idx   <= w_last_word ? '0 : r_rd_idx + ADDR_WIDTH'(1);
                r_rd_bank  <= w_last_word ? w_rd_bank_nxt : r_rd_bank;
            end else if (rd_ready) begin
                r_rd_valid <= 1'b0;
            end
            r_frames <= r_frames + CW'(w_close) - CW'(w_last_issue);
        end
    end
endmodule

// File: tb/tb_pingpong_frame_buf.sv
// tb_pingpong_frame_buf: 2-bank and 3-bank instances checked cycle by cycle against a queue-based frame model
module tb_pingpong_frame_buf;
    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       rst, wr_valid, wr_last, rd_ready, rnd;
    logic [7:0] wr_data;
    logic       wr_ready [2];
    logic       rd_valid [2];
    logic       rd_last  [2];
    logic [7:0] rd_data  [2];
    logic [1:0] frames   [2];
`ifdef PINGPONG_FRAME_BUF_LEN_EN
    logic [5:0] rd_len   [2];
    logic       rd_first [2];
`endif
    int passes = 0;
    int total  = 0;
    int n;

    always #5 clk = ~clk;

    pingpong_frame_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_BANKS(2)) u0 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready[0]),
        .wr_data(wr_data), .wr_last(wr_last), .rd_valid(rd_valid[0]),
        .rd_ready(rd_ready), .rd_data(rd_data[0]), .rd_last(rd_last[0]),
`ifdef PINGPONG_FRAME_BUF_LEN_EN
        .rd_len(rd_len[0]), .rd_first(rd_first[0]),
`endif
        .frames_avail(frames[0])
    );

    pingpong_frame_buf #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .NUM_BANKS(3)) u1 (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready[1]),
        .wr_data(wr_data), .wr_last(wr_last), .rd_valid(rd_valid[1]),
        .rd_ready(rd_ready), .rd_data(rd_data[1]), .rd_last(rd_last[1]),
`ifdef PINGPONG_FRAME_BUF_LEN_EN
        .rd_len(rd_len[1]), .rd_first(rd_first[1]),
`endif
        .frames_avail(frames[1])
    );

    // model: closed frames as a word queue {len, first, last, data}, the open frame, and the output word
    int         nb [2] = '{2, 3};
    logic [15:0] m_pend [2][$];
    logic [7:0]  m_part [2][$];
    int          m_cnt  [2];
    logic        m_v [2], m_l [2], m_f [2];
    logic [7:0]  m_d [2];
    logic [5:0]  m_len [2];

    task automatic model(int d);
        bit fire, close, issue;
        logic [15:0] e;
        int sz;
        if (rst) begin
            m_pend[d].delete(); m_part[d].delete();
            m_cnt[d] = 0; m_v[d] = 0; m_l[d] = 0; m_f[d] = 0; m_d[d] = 0; m_len[d] = 0;
            return;
        end
        fire  = wr_valid && (m_cnt[d] < nb[d]);
        close = fire && (wr_last || m_part[d].size() == DEPTH-1);
        issue = (m_cnt[d] > 0) && (!m_v[d] || rd_ready);
        if (issue) begin
            e = m_pend[d].pop_front();
            m_v[d] = 1; m_d[d] = e[7:0]; m_l[d] = e[8]; m_f[d] = e[9]; m_len[d] = e[15:10];
            if (e[8]) m_cnt[d]--;
        end else if (m_v[d] && rd_ready) begin
            m_v[d] = 0;
        end
        if (fire) m_part[d].push_back(wr_data);
        if (close) begin
            sz = m_part[d].size();
            for (int i = 0; i < sz; i++)
                m_pend[d].push_back({6'(sz), i == 0, i == sz-1, m_part[d][i]});
            m_part[d].delete();
            m_cnt[d]++;
        end
    endtask

    task automatic chk(string tag, int d, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s[%0d]: got %0h expected %0h", tag, d, got, exp);
    endtask

    task automatic tick();
        logic [7:0] pd;
        logic pv, pr;
        pd = rd_data[0]; pv = rd_valid[0]; pr = rd_ready;
        model(0); model(1);
        @(posedge clk); #1;
        for (int d = 0; d < 2; d++) begin
            chk("wr_ready", d, wr_ready[d], m_cnt[d] < nb[d]);
            chk("rd_valid", d, rd_valid[d], m_v[d]);
            chk("rd_data",  d, rd_data[d],  m_d[d]);
            chk("rd_last",  d, rd_last[d],  m_l[d]);
            chk("frames",   d, frames[d],   m_cnt[d]);
`ifdef PINGPONG_FRAME_BUF_LEN_EN
            chk("rd_first", d, rd_first[d], m_f[d]);
            chk("rd_len",   d, rd_len[d],   m_len[d]);
`endif
        end
        if (!rst && pv && !pr) chk("hold", 0, rd_data[0], pd);
    endtask

    task automatic idle(int c);
        wr_valid = 0; wr_last = 0;
        repeat (c) tick();
    endtask

    // offer one word until the 2-bank model predicts a handshake; returns cycles taken
    task automatic wr_word(logic [7:0] dat, logic last, output int cyc);
        bit acc;
        wr_valid = 1; wr_data = dat; wr_last = last; cyc = 0;
        do begin
            acc = (m_cnt[0] < 2);
            if (rnd) rd_ready = 1'($urandom_range(0, 1));
            tick();
            cyc++;
        end while (!acc && cyc < 200);
        chk("wr_accept", 0, acc, 1);
    endtask

    task automatic wr_frame(logic [7:0] base, int len);
        int c;
        for (int i = 0; i < len; i++) wr_word(base + 8'(i), i == len-1, c);
    endtask

    initial begin
        rst = 1; wr_valid = 0; wr_last = 0; wr_data = 0; rd_ready = 1; rnd = 0;
        tick(); tick();
        chk("rst_valid", 0, rd_valid[0], 0);
        chk("rst_frames", 0, frames[0], 0);
        chk("rst_ready", 0, wr_ready[0], 1);
        rst = 0;

        for (int i = 0; i < 32; i++) begin
            wr_valid = 1; wr_data = 8'(i); wr_last = 0;
            tick();
        end
        wr_valid = 0;
        chk("lat_edge0", 0, rd_valid[0], 0);
        tick();
        chk("lat_edge1", 0, rd_valid[0], 1);
        chk("lat_data", 0, rd_data[0], 0);
        idle(34);

        wr_frame(8'hA0, 5);
        wr_frame(8'hB0, 3);
        idle(12);

        rd_ready = 0;
        wr_frame(8'h10, 4);
        wr_frame(8'h20, 4);
        chk("full_frames", 0, frames[0], 2);
        chk("full_ready", 0, wr_ready[0], 0);
        wr_valid = 1; wr_data = 8'h30; wr_last = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("refused", 0, wr_ready[0], 0);
        end
        rd_ready = 1;
        wr_word(8'h30, 0, n);
        chk("release_cycles", 0, n, 4);
        for (int i = 1; i < 4; i++) wr_word(8'h30 + 8'(i), i == 3, n);
        idle(20);

        rst = 1; idle(1); rst = 0; rd_ready = 1;
        for (int k = 0; k < 7; k++) begin
            wr_word(8'h50 + 8'(k), 1, n);
            if (k > 0) chk("same_cycle", 1, frames[1], 1);
        end
        idle(5);

        rst = 1; idle(1); rst = 0; rnd = 1;
        for (int f = 0; f < 10; f++) begin
            int len;
            len = $urandom_range(1, 32);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    wr_valid = 0; rd_ready = 1'($urandom_range(0, 1));
                    tick();
                end
                wr_word(8'($urandom), i == len-1, n);
            end
        end
        rnd = 0; wr_valid = 0;
        for (int i = 0; i < 200; i++) begin
            rd_ready = 1'($urandom_range(0, 1));
            tick();
        end
        rd_ready = 1;
        idle(40);

        rst = 1; idle(1); rst = 0; rd_ready = 0;
        wr_frame(8'h60, 6);
        wr_frame(8'h70, 4);
        wr_valid = 0; rd_ready = 1;
        tick(); tick();
        rst = 1; tick();
        chk("mid_rst_valid", 0, rd_valid[0], 0);
        chk("mid_rst_frames", 0, frames[0], 0);
        chk("mid_rst_ready", 0, wr_ready[0], 1);
        rst = 0;
        wr_frame(8'h80, 8);
        idle(15);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
